// File: rtl/y86_mem_responder.sv
// Memory responder for the multi-cycle Y86-64 core: one request at a time, byte-addressed
// little-endian storage, programmable wait latency, registered response with error flag.
module y86_mem_responder #(
    parameter int MEM_BYTES = 4096,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic [79:0] rsp_instr,
    output logic        rsp_error
);
    localparam int MW = $clog2(MEM_BYTES);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [79:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [MEM_BYTES];

    logic            accept, commit, c_err;
    logic [1:0]      c_op;
    logic [63:0]     c_addr, c_wdata;
    logic [64:0]     c_size;
    logic [9:0][MW-1:0] idx;
    logic [9:0][7:0]    rd_bytes;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;
    assign commit = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));

    // With zero latency the access commits on the acceptance edge, straight from the request bus.
    assign c_op    = (state_q == IDLE) ? req_op    : op_q;
    assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign c_size  = (c_op == OP_FETCH) ? 65'd10 : 65'd8;
    assign c_err   = (c_op == OP_RSVD) || (({1'b0, c_addr} + c_size) > 65'(MEM_BYTES));

    // Out-of-range accesses are steered to byte 0 so no lane ever indexes past the array.
    always_comb begin
        idx      = '0;
        rd_bytes = '0;
        for (int i = 0; i < 10; i++) begin
            idx[i]      = c_err ? '0 : c_addr[MW-1:0] + MW'(i);
            rd_bytes[i] = mem_q[idx[i]];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        instr_d     = instr_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) state_d = IDLE;
                else                          rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = c_err;
            rdata_d = (!c_err && (c_op == OP_READ))  ? rd_bytes[7:0] : '0;
            instr_d = (!c_err && (c_op == OP_FETCH)) ? rd_bytes      : '0;
        end
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            instr_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
        end
    end

    // Storage is never cleared; commit cannot fire while reset holds the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (commit && !c_err && (c_op == OP_WRITE)) begin
            for (int i = 0; i < 8; i++) mem_q[idx[i]] <= c_wdata[8*i +: 8];
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_instr = instr_q;
    assign rsp_error = err_q;
endmodule

// File: tb/tb_y86_mem_responder.sv
// Bench for y86_mem_responder: byte-array model with a response queue, per-cycle compare,
// directed spec scenarios, randomized traffic, plus a zero-latency instance.
module tb_y86_mem_responder;
    localparam int MB = 4096;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_error;
    logic [1:0]  req_op = 0;
    logic [63:0] req_addr = 0, req_wdata = 0, rsp_rdata;
    logic [79:0] rsp_instr;

    logic        req_valid0 = 0, req_ready0, rsp_valid0, rsp_ready0 = 1, rsp_error0;
    logic [1:0]  req_op0 = 0;
    logic [63:0] req_addr0 = 0, req_wdata0 = 0, rsp_rdata0;
    logic [79:0] rsp_instr0;

    y86_mem_responder #(.MEM_BYTES(MB), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_instr(rsp_instr), .rsp_error(rsp_error));

    y86_mem_responder #(.MEM_BYTES(MB), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_op(req_op0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_instr(rsp_instr0), .rsp_error(rsp_error0));

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: flat byte array plus queue of responses owed, each with its due cycle.
    typedef struct { int due; logic [63:0] rd; logic [79:0] ins; logic err; } exp_t;
    logic [7:0] mdl [MB];
    exp_t q[$];
    logic ready_ok = 1'b0, ghost = 1'b0, prev_v = 1'b0, last_err;
    int   vcyc = 0;
    logic [63:0] last_rd;
    logic [79:0] last_ins;

    function automatic exp_t predict(input logic [1:0] op, input logic [63:0] a,
                                     input logic [63:0] wd, input int due);
        exp_t e;
        int n = (op == 2'b10) ? 10 : 8;
        logic [64:0] lim = {1'b0, a} + 65'(n);
        e.due = due; e.rd = '0; e.ins = '0;
        e.err = (op == 2'b11) || (lim > 65'(MB));
        if (!e.err) begin
            for (int i = 0; i < n; i++) begin
                if (op == 2'b00) e.rd[8*i +: 8] = mdl[int'(a) + i];
                if (op == 2'b10) e.ins[8*i +: 8] = mdl[int'(a) + i];
                if (op == 2'b01) mdl[int'(a) + i] = wd[8*i +: 8];
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) ready_ok <= rst_n;

    always @(negedge clk) begin
        logic exp_rr;
        exp_rr = ready_ok && (q.size() == 0) && !ghost;
        chk("req_ready", req_ready, exp_rr);
        if (q.size() > 0) begin
            if (cyc < q[0].due) chk("rsp_valid_early", rsp_valid, 0);
            else begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_rdata", rsp_rdata, q[0].rd);
                chk("rsp_instr", rsp_instr, q[0].ins);
                chk("rsp_error", rsp_error, q[0].err);
                if (rsp_valid && rsp_ready) begin
                    last_rd = rsp_rdata; last_ins = rsp_instr; last_err = rsp_error;
                    q.delete(0);
                end
            end
        end else chk("rsp_valid_idle", rsp_valid, 0);
        if (rsp_valid && !prev_v) vcyc = cyc;
        prev_v = rsp_valid;
    end

    task automatic do_req(input logic [1:0] op, input logic [63:0] a, input logic [63:0] wd,
                          input bit model, output int t);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1; req_op = op; req_addr = a; req_wdata = wd;
        do begin @(negedge clk); n++; end while (!req_ready && n < 200);
        if (!req_ready) chk("req_accept_timeout", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0; req_wdata = {$urandom, $urandom}; req_addr = {$urandom, $urandom};
        t = cyc;
        if (model) q.push_back(predict(op, a, wd, t + L + 1));
        else ghost = 1'b1;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            if (rnd) rsp_ready = 1'($urandom % 2);
            n++;
        end
        if (q.size() > 0) begin chk("rsp_timeout", q.size(), 0); q.delete(); end
        rsp_ready = 1;
    endtask

    task automatic run(input logic [1:0] op, input logic [63:0] a, input logic [63:0] wd,
                       input bit rnd);
        int t;
        do_req(op, a, wd, 1, t);
        drain(rnd);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        if (!rsp_valid) chk("wait_valid_timeout", rsp_valid, 1);
    endtask

    task automatic do0(input logic [1:0] op, input logic [63:0] a, input logic [63:0] wd,
                       output int t, output int vc, output logic [63:0] rd,
                       output logic [79:0] ins, output logic err);
        int n = 0;
        @(posedge clk); #1;
        req_valid0 = 1; req_op0 = op; req_addr0 = a; req_wdata0 = wd;
        do begin @(negedge clk); n++; end while (!req_ready0 && n < 50);
        if (!req_ready0) chk("dut0_accept_timeout", req_ready0, 1);
        @(posedge clk); #1;
        req_valid0 = 0; t = cyc; n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid0 && n < 50);
        if (!rsp_valid0) chk("dut0_rsp_timeout", rsp_valid0, 1);
        vc = cyc; rd = rsp_rdata0; ins = rsp_instr0; err = rsp_error0;
        @(posedge clk); #1;
    endtask

    initial begin
        int t, vc;
        logic [63:0] rd, a;
        logic [79:0] ins;
        logic err;
        logic [1:0] op;

        repeat (3) @(posedge clk); #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_instr", rsp_instr, 0);
        chk("reset_rsp_error", rsp_error, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("req_ready_after_release", req_ready, 1);

        for (int i = 0; i < MB; i += 8) run(2'b01, 64'(i), {$urandom, $urandom}, 0);

        // irmovq image, bytes 0..9 = 30 F4 88 77 66 55 44 33 22 11
        run(2'b01, 64'd0, 64'h3344556677_88F430, 0);
        run(2'b01, 64'd2, 64'h1122334455667788, 0);
        do_req(2'b10, 64'd0, 64'd0, 1, t);
        drain(0);
        chk("t1_latency", vcyc, t + 3);
        chk("t1_instr", last_ins, 80'h1122334455667788F430);
        chk("t1_error", last_err, 0);

        run(2'b01, 64'h100, 64'h0123456789ABCDEF, 0);
        run(2'b00, 64'h100, 64'd0, 0);
        chk("t2_rdata", last_rd, 64'h0123456789ABCDEF);
        run(2'b00, 64'h107, 64'd0, 0);
        chk("t2_byte107", last_rd[7:0], 8'h01);
        run(2'b00, 64'h0FF, 64'd0, 0);
        chk("t2_byte100", last_rd[15:8], 8'hEF);

        run(2'b00, 64'd4088, 64'd0, 0);  chk("t3_rd4088_err", last_err, 0);
        run(2'b00, 64'd4089, 64'd0, 0);  chk("t3_rd4089_err", last_err, 1);
        chk("t3_rd4089_data", last_rd, 0);
        run(2'b10, 64'd4086, 64'd0, 0);  chk("t3_f4086_err", last_err, 0);
        run(2'b10, 64'd4087, 64'd0, 0);  chk("t3_f4087_err", last_err, 1);
        run(2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0); chk("t3_wrap_err", last_err, 1);
        run(2'b01, 64'd4090, 64'hFFFF_FFFF_FFFF_FFFF, 0); chk("t3_wr4090_err", last_err, 1);
        run(2'b10, 64'd4086, 64'd0, 0);

        // Backpressure with a competing request that must be ignored
        rsp_ready = 0;
        do_req(2'b00, 64'h40, 64'd0, 1, t);
        wait_valid();
        @(posedge clk); #1;
        req_valid = 1; req_op = 2'b01; req_addr = 64'h48; req_wdata = '1;
        repeat (5) @(posedge clk);
        #1 req_valid = 0; rsp_ready = 1;
        drain(0);
        @(negedge clk);
        chk("t4_req_ready_back", req_ready, 1);
        run(2'b00, 64'h48, 64'd0, 0);

        // Reset during WAIT of a write: write is lost
        run(2'b01, 64'h200, 64'd0, 0);
        do_req(2'b01, 64'h200, 64'hDEADBEEFCAFEF00D, 0, t);
        rst_n = 0; ghost = 0;
        #1;
        chk("t5_rsp_valid_rst", rsp_valid, 0);
        chk("t5_req_ready_rst", req_ready, 0);
        repeat (2) @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("t5_req_ready_release", req_ready, 1);
        run(2'b00, 64'h200, 64'd0, 0);
        chk("t5_read_old", last_rd, 64'd0);

        // Reset while a response is being held
        rsp_ready = 0;
        do_req(2'b00, 64'h208, 64'd0, 1, t);
        wait_valid();
        @(posedge clk); #1;
        rst_n = 0; q.delete();
        #1 chk("t5_rsp_drop", rsp_valid, 0);
        repeat (2) @(posedge clk); #1 rst_n = 1; rsp_ready = 1;

        for (int k = 0; k < 300; k++) begin
            int r = $urandom % 10;
            op = 2'($urandom % 4);
            if (r < 7)      a = 64'($urandom % MB);
            else if (r < 9) a = 64'(MB - 12 + $urandom % 12);
            else            a = {$urandom, $urandom};
            run(op, a, {$urandom, $urandom}, 1);
        end

        do0(2'b01, 64'h10, 64'hA5A5010203040506, t, vc, rd, ins, err);
        do0(2'b00, 64'h10, 64'd0, t, vc, rd, ins, err);
        chk("t6_latency0", vc, t + 1);
        chk("t6_rdata0", rd, 64'hA5A5010203040506);
        chk("t6_err0", err, 0);
        do0(2'b11, 64'h10, 64'd0, t, vc, rd, ins, err);
        chk("t6_rsvd_err", err, 1);
        chk("t6_rsvd_rdata", rd, 0);
        chk("t6_rsvd_instr", ins, 0);
        do0(2'b00, 64'd4089, 64'd0, t, vc, rd, ins, err);
        chk("t6_range_err", err, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
